pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
//  Module   : pipe_stall_ctrl
//  Brief    : Pipeline stall/flush controller for an N-stage in-order core.
//             Merges level stall requests, a fixed-length timed stall and an
//             exception flush into per-stage stall/flush/bubble controls, and
//             keeps saturating stall/flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
    parameter int N_STAGES = 5,
    parameter int SEL_W    = 3,
    parameter int LEN_W    = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_STAGES-1:0] stall_req,
    input  logic                timed_valid,
    input  logic [SEL_W-1:0]    timed_stage,
    input  logic [LEN_W-1:0]    timed_len,
    input  logic                flush_req,
    input  logic [SEL_W-1:0]    flush_stage,
    output logic [N_STAGES-1:0] stall,
    output logic [N_STAGES-1:0] flush,
    output logic [N_STAGES-1:0] bubble,
    output logic                timer_busy,
    output logic                overrun,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    flush_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Timer and counter state
    logic [LEN_W-1:0] r_count_q,        r_count_d;
    logic [SEL_W-1:0] r_tstage_q,       r_tstage_d;
    logic             r_overrun_q,      r_overrun_d;
    logic [CNT_W-1:0] r_stall_cycles_q, r_stall_cycles_d;
    logic [CNT_W-1:0] r_flush_count_q,  r_flush_count_d;

    logic                w_busy;
    logic                w_start;
    logic                w_start_blocked;
    logic                w_timer_flushed;
    logic [N_STAGES-1:0] w_timed_hit;
    logic [N_STAGES-1:0] w_eff;
    logic [N_STAGES-1:0] w_raw_stall;
    logic [N_STAGES-1:0] w_flush;
    logic [N_STAGES-1:0] w_stall;
    logic [N_STAGES-1:0] w_bubble;

    // The timer is busy while any count remains; the issue cycle itself is
    // covered by w_start, so a length-L stall holds for exactly L cycles.
    assign w_busy          = (r_count_q != '0);
    assign w_start         = timed_valid & ~w_busy & (timed_len != '0);
    // A flush covering the requesting stage kills the request before it runs.
    assign w_start_blocked = flush_req & (timed_stage <= flush_stage);
    // A flush covering the owning stage cancels a running timed stall.
    assign w_timer_flushed = flush_req & w_busy & (r_tstage_q <= flush_stage);

    // Per-stage request merge, priority stall vector and flush mask.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        assign w_timed_hit[i] = (w_busy  & (r_tstage_q  == SEL_W'(i))) |
                                (w_start & (timed_stage == SEL_W'(i)));
        assign w_eff[i]       = stall_req[i] | w_timed_hit[i];
        // An older stage's request holds itself and every younger stage.
        assign w_raw_stall[i] = |w_eff[N_STAGES-1:i];
        // flush_stage beyond the last stage naturally flushes everything.
        assign w_flush[i]     = flush_req & (flush_stage >= SEL_W'(i));
        assign w_stall[i]     = w_raw_stall[i] & ~w_flush[i];
    end

    // A stage emits a bubble when it holds but the next-older stage advances.
    for (genvar i = 0; i < N_STAGES - 1; i++) begin : g_bubble
        assign w_bubble[i] = w_stall[i] & ~w_stall[i+1] & ~w_flush[i+1];
    end
    assign w_bubble[N_STAGES-1] = w_stall[N_STAGES-1];

    // Next-state for the timed-stall timer, overrun flag and counters.
    always_comb begin
        r_count_d        = r_count_q;
        r_tstage_d       = r_tstage_q;
        r_overrun_d      = r_overrun_q;
        r_stall_cycles_d = r_stall_cycles_q;
        r_flush_count_d  = r_flush_count_q;

        if (w_timer_flushed) begin
            r_count_d = '0;
        end else if (w_busy) begin
            r_count_d = r_count_q - LEN_W'(1);
        end else if (w_start && !w_start_blocked) begin
            r_count_d  = timed_len - LEN_W'(1);
            r_tstage_d = timed_stage;
        end

        if (timed_valid && w_busy) begin
            r_overrun_d = 1'b1;
        end

        if (w_stall[0] && (r_stall_cycles_q != C_CNT_MAX)) begin
            r_stall_cycles_d = r_stall_cycles_q + CNT_W'(1);
        end

        if (flush_req && (r_flush_count_q != C_CNT_MAX)) begin
            r_flush_count_d = r_flush_count_q + CNT_W'(1);
        end
    end

    // State registers; reset overrides everything, including a live timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q        <= '0;
            r_tstage_q       <= '0;
            r_overrun_q      <= 1'b0;
            r_stall_cycles_q <= '0;
            r_flush_count_q  <= '0;
        end else begin
            r_count_q        <= r_count_d;
            r_tstage_q       <= r_tstage_d;
            r_overrun_q      <= r_overrun_d;
            r_stall_cycles_q <= r_stall_cycles_d;
            r_flush_count_q  <= r_flush_count_d;
        end
    end

    assign stall        = w_stall;
    assign flush        = w_flush;
    assign bubble       = w_bubble;
    assign timer_busy   = w_busy;
    assign overrun      = r_overrun_q;
    assign stall_cycles = r_stall_cycles_q;
    assign flush_count  = r_flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_stall_ctrl
//  Brief    : Scoreboard bench for pipe_stall_ctrl. Driver applies directed
//             vectors and queues hand-computed expectations; a monitor pops
//             and compares each cycle on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] stall_req;
    logic       timed_valid;
    logic [2:0] timed_stage;
    logic [3:0] timed_len;
    logic       flush_req;
    logic [2:0] flush_stage;

    logic [4:0]  stall, flush, bubble;
    logic        timer_busy, overrun;
    logic [31:0] stall_cycles, flush_count;

    // Saturation instance (CNT_W = 4)
    logic [4:0] s_stall_req;
    logic [4:0] s_stall, s_flush, s_bubble;
    logic       s_busy, s_overrun;
    logic [3:0] s_stall_cycles, s_flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        logic [4:0]  st;
        logic [4:0]  fl;
        logic [4:0]  bb;
        logic        busy;
        logic        ovr;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [3:0]  sat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.N_STAGES(5), .SEL_W(3), .LEN_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .timed_valid(timed_valid), .timed_stage(timed_stage), .timed_len(timed_len),
        .flush_req(flush_req), .flush_stage(flush_stage),
        .stall(stall), .flush(flush), .bubble(bubble),
        .timer_busy(timer_busy), .overrun(overrun),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_stall_ctrl #(.N_STAGES(5), .SEL_W(3), .LEN_W(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_req(s_stall_req),
        .timed_valid(1'b0), .timed_stage(3'd0), .timed_len(4'd0),
        .flush_req(1'b0), .flush_stage(3'd0),
        .stall(s_stall), .flush(s_flush), .bubble(s_bubble),
        .timer_busy(s_busy), .overrun(s_overrun),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_req   = '0;
        timed_valid = 1'b0;
        timed_stage = '0;
        timed_len   = '0;
        flush_req   = 1'b0;
        flush_stage = '0;
    endtask

    task automatic expect_v(input string nm, input logic [4:0] st, input logic [4:0] fl,
                            input logic [4:0] bb, input logic busy, input logic ovr,
                            input int sc, input int fc, input int sat);
        exp_t e;
        e.nm = nm; e.st = st; e.fl = fl; e.bb = bb; e.busy = busy; e.ovr = ovr;
        e.sc = 32'(sc); e.fc = 32'(fc); e.sat = 4'(sat);
        sb.push_back(e);
    endtask

    // Monitor: compare the full observable state once per cycle
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if (stall !== e.st || flush !== e.fl || bubble !== e.bb ||
                    timer_busy !== e.busy || overrun !== e.ovr ||
                    stall_cycles !== e.sc || flush_count !== e.fc ||
                    s_stall_cycles !== e.sat) begin
                    n_fail++;
                    $display("FAIL %s: got st=%b fl=%b bb=%b busy=%b ovr=%b sc=%0d fc=%0d sat=%0d, want st=%b fl=%b bb=%b busy=%b ovr=%b sc=%0d fc=%0d sat=%0d",
                             e.nm, stall, flush, bubble, timer_busy, overrun,
                             stall_cycles, flush_count, s_stall_cycles,
                             e.st, e.fl, e.bb, e.busy, e.ovr, e.sc, e.fc, e.sat);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        s_stall_req = '0;
        idle();

        // Reset state
        tick(); expect_v("reset", 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
        tick(); rst = 1'b0;
        expect_v("idle", 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);

        // Level priority
        tick(); stall_req = 5'b00100;
        expect_v("lvl_s2", 5'b00111, 5'b00000, 5'b00100, 0, 0, 0, 0, 0);
        tick(); stall_req = 5'b10001;
        expect_v("lvl_s4s0", 5'b11111, 5'b00000, 5'b10000, 0, 0, 1, 0, 0);
        tick(); stall_req = 5'b00000;
        expect_v("lvl_none", 5'b00000, 5'b00000, 5'b00000, 0, 0, 2, 0, 0);

        // Timed stall, stage 2, length 3
        tick(); timed_valid = 1'b1; timed_stage = 3'd2; timed_len = 4'd3;
        expect_v("tmd_issue", 5'b00111, 5'b00000, 5'b00100, 0, 0, 2, 0, 0);
        tick(); idle();
        expect_v("tmd_c1", 5'b00111, 5'b00000, 5'b00100, 1, 0, 3, 0, 0);
        tick(); expect_v("tmd_c2", 5'b00111, 5'b00000, 5'b00100, 1, 0, 4, 0, 0);
        tick(); expect_v("tmd_end", 5'b00000, 5'b00000, 5'b00000, 0, 0, 5, 0, 0);

        // Overrun: len 4 on stage 1, second request one cycle later
        tick(); timed_valid = 1'b1; timed_stage = 3'd1; timed_len = 4'd4;
        expect_v("ovr_issue", 5'b00011, 5'b00000, 5'b00010, 0, 0, 5, 0, 0);
        tick(); timed_stage = 3'd3; timed_len = 4'd2;
        expect_v("ovr_second", 5'b00011, 5'b00000, 5'b00010, 1, 0, 6, 0, 0);
        tick(); idle();
        expect_v("ovr_c2", 5'b00011, 5'b00000, 5'b00010, 1, 1, 7, 0, 0);
        tick(); expect_v("ovr_c3", 5'b00011, 5'b00000, 5'b00010, 1, 1, 8, 0, 0);
        tick(); expect_v("ovr_end", 5'b00000, 5'b00000, 5'b00000, 0, 1, 9, 0, 0);
        tick(); timed_valid = 1'b1; timed_stage = 3'd2; timed_len = 4'd0;
        expect_v("len0", 5'b00000, 5'b00000, 5'b00000, 0, 1, 9, 0, 0);
        tick(); idle();
        expect_v("len0_after", 5'b00000, 5'b00000, 5'b00000, 0, 1, 9, 0, 0);

        // Request in the cycle the count reaches 0 is ignored
        tick(); timed_valid = 1'b1; timed_stage = 3'd0; timed_len = 4'd2;
        expect_v("last_issue", 5'b00001, 5'b00000, 5'b00001, 0, 1, 9, 0, 0);
        tick(); timed_stage = 3'd4; timed_len = 4'd3;
        expect_v("last_req", 5'b00001, 5'b00000, 5'b00001, 1, 1, 10, 0, 0);
        tick(); idle();
        expect_v("last_ign1", 5'b00000, 5'b00000, 5'b00000, 0, 1, 11, 0, 0);
        tick(); expect_v("last_ign2", 5'b00000, 5'b00000, 5'b00000, 0, 1, 11, 0, 0);

        // Flush override of a running timer plus a younger level request
        tick(); timed_valid = 1'b1; timed_stage = 3'd2; timed_len = 4'd5; stall_req = 5'b10000;
        expect_v("fo_issue", 5'b11111, 5'b00000, 5'b10000, 0, 1, 11, 0, 0);
        tick(); timed_valid = 1'b0; flush_req = 1'b1; flush_stage = 3'd3;
        expect_v("fo_flush", 5'b10000, 5'b01111, 5'b10000, 1, 1, 12, 0, 0);
        tick(); flush_req = 1'b0; flush_stage = 3'd0;
        expect_v("fo_cleared", 5'b11111, 5'b00000, 5'b10000, 0, 1, 12, 1, 0);
        tick(); idle();
        expect_v("fo_idle", 5'b00000, 5'b00000, 5'b00000, 0, 1, 13, 1, 0);

        // Flush coinciding with timed_valid on a flushed stage: no start
        tick(); timed_valid = 1'b1; timed_stage = 3'd1; timed_len = 4'd3;
        flush_req = 1'b1; flush_stage = 3'd2;
        expect_v("fv_coinc", 5'b00000, 5'b00111, 5'b00000, 0, 1, 13, 1, 0);
        tick(); idle();
        expect_v("fv_nostart", 5'b00000, 5'b00000, 5'b00000, 0, 1, 13, 2, 0);

        // flush_stage beyond the last stage flushes all
        tick(); flush_req = 1'b1; flush_stage = 3'd7; stall_req = 5'b11111;
        expect_v("fl_all", 5'b00000, 5'b11111, 5'b00000, 0, 1, 13, 2, 0);
        tick(); flush_req = 1'b1; flush_stage = 3'd0; stall_req = 5'b00100;
        expect_v("fl_s0", 5'b00110, 5'b00001, 5'b00100, 0, 1, 13, 3, 0);
        tick(); idle();
        expect_v("fl_idle", 5'b00000, 5'b00000, 5'b00000, 0, 1, 13, 4, 0);

        // Reset in the middle of a length-10 timed stall
        tick(); timed_valid = 1'b1; timed_stage = 3'd3; timed_len = 4'd10;
        expect_v("rm_issue", 5'b01111, 5'b00000, 5'b01000, 0, 1, 13, 4, 0);
        tick(); idle();
        expect_v("rm_c1", 5'b01111, 5'b00000, 5'b01000, 1, 1, 14, 4, 0);
        tick(); expect_v("rm_c2", 5'b01111, 5'b00000, 5'b01000, 1, 1, 15, 4, 0);
        tick(); rst = 1'b1;
        expect_v("rm_rst", 5'b01111, 5'b00000, 5'b01000, 1, 1, 16, 4, 0);
        tick(); rst = 1'b0;
        expect_v("rm_after", 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);

        // Saturation of a 4-bit stall counter
        for (int k = 0; k < 20; k++) begin
            tick(); s_stall_req = 5'b00001;
            expect_v("sat_hold", 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, (k < 15) ? k : 15);
        end
        tick(); s_stall_req = 5'b00000;
        expect_v("sat_stay", 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 15);
        tick(); expect_v("sat_stay2", 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 15);

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
